apb_slave_regfile: RTL

//  APB completer terminating the m_apb side of axi_lite_to_apb: a DEPTH-word register file

---
 rtl/apb_slave_pkg.sv | 28 ++
 rtl/apb_regfile_ram.sv | 38 +++
 rtl/apb_slave_regfile.sv | 116 +++++++++++
 3 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types, widths and address-check helper for the APB register-file completer.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_slv_state_t;

    localparam int unsigned ERR_CNT_W  = 16;
    localparam int unsigned WAIT_CNT_W = 4;
    localparam int unsigned CHK_ADDR_W = 64;

    // Flags an address that is misaligned or has any bit set above the word-index field.
    function automatic logic is_bad_addr(input logic [CHK_ADDR_W-1:0] addr,
                                         input int unsigned           addr_lsb,
                                         input int unsigned           idx_top);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < CHK_ADDR_W; i++) begin
            if (((i < addr_lsb) || (i >= idx_top)) && addr[i]) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/apb_regfile_ram.sv
// DEPTH x DW storage: one write port, one registered read port, cleared by reset.
module apb_regfile_ram #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Array update; reset clears every word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds data only in the cycle after a read strobe, zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= re ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: register file with programmable wait states, address error response
// and a saturating error counter.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int unsigned AW_APB      = 32,
    parameter int unsigned DW_APB      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                 apb_clk,
    input  logic                 sys_aresetn,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [AW_APB-1:0]    paddr,
    input  logic [DW_APB-1:0]    pwdata,
    output logic                 pready,
    output logic [DW_APB-1:0]    prdata,
    output logic                 pslverr,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned ADDR_LSB = $clog2(DW_APB / 8);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned IDX_TOP  = ADDR_LSB + IDX_W;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic NO_WAIT = (WAIT_CYCLES == 0);

    apb_slv_state_t          state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [IDX_W-1:0]        idx;
    logic                    bad_addr;
    logic                    access;
    logic                    resp_enter;
    logic                    ram_we;
    logic                    ram_re;

    assign idx      = paddr[IDX_TOP-1:ADDR_LSB];
    assign bad_addr = is_bad_addr(CHK_ADDR_W'(paddr), ADDR_LSB, IDX_TOP);
    assign access   = psel & penable;

    // Marks the edge that moves the FSM into RESP; the response is captured on that edge.
    always_comb begin
        resp_enter = 1'b0;
        case (state)
            IDLE:    resp_enter = access & ~pready & NO_WAIT;
            WAIT:    resp_enter = access & (wait_cnt == WAIT_LAST);
            default: resp_enter = 1'b0;
        endcase
    end

    assign ram_we = resp_enter &  pwrite & ~bad_addr;
    assign ram_re = resp_enter & ~pwrite & ~bad_addr;

    apb_regfile_ram #(
        .DW    (DW_APB),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (apb_clk),
        .rst_n (sys_aresetn),
        .we    (ram_we),
        .waddr (idx),
        .wdata (pwdata),
        .re    (ram_re),
        .raddr (idx),
        .rdata (prdata)
    );

    // Transfer FSM, wait counter, registered response and error counter.
    always_ff @(posedge apb_clk or negedge sys_aresetn) begin
        if (!sys_aresetn) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            err_count <= '0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !pready) begin
                        if (NO_WAIT) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (!access) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= RESP;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (resp_enter) begin
                pready  <= 1'b1;
                pslverr <= bad_addr;
                if (bad_addr && (err_count != '1)) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule
